// File: rtl/ibex_bus_pkg.sv
// Shared types for the Ibex two-host bus fabric: decode targets, host IDs
// and the one-deep response slot that carries a grant into its response cycle.
package ibex_bus_pkg;

  typedef enum logic [1:0] {
    TgtSram = 2'd0,
    TgtLed  = 2'd1,
    TgtErr  = 2'd2
  } bus_target_e;

  typedef enum logic {
    HostInstr = 1'b0,
    HostData  = 1'b1
  } bus_host_e;

  // we marks data writes so their response carries zero read data.
  typedef struct packed {
    logic        valid;
    bus_host_e   host;
    bus_target_e target;
    logic        we;
    logic [31:0] led_rdata;
  } bus_rsp_slot_t;

endpackage

// File: rtl/ibex_bus_decode.sv
// Pure combinational address decode to SRAM, LED register or error target.
// SRAM takes precedence if the LED word ever falls inside the SRAM window.
module ibex_bus_decode
  import ibex_bus_pkg::*;
#(
  parameter int unsigned MemSize  = 65536,
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter logic [31:0] LedAddr  = 32'h8000_0000
) (
  input  logic [31:0] addr,
  output bus_target_e target
);

  localparam logic [31:0] MemMask = ~(32'(MemSize) - 32'd1);

  // NOTE: target gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    target = TgtErr;
    if ((addr & MemMask) == MemStart) begin
      target = TgtSram;
    end else if (addr[31:2] == LedAddr[31:2]) begin
      target = TgtLed;
    end
  end

endmodule

// File: rtl/ibex_bus_arbiter.sv
// Two-host (instr/data) to SRAM + LED fabric with a fairness bit, one
// transaction per cycle and a fixed one-cycle response pipeline.
module ibex_bus_arbiter
  import ibex_bus_pkg::*;
#(
  parameter int unsigned MemSize  = 65536,
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter logic [31:0] LedAddr  = 32'h8000_0000,
  parameter int unsigned LedWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_req_i,
  input  logic [31:0]         instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [31:0]         instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [3:0]          data_be_i,
  input  logic [31:0]         data_addr_i,
  input  logic [31:0]         data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic                data_err_o,
  output logic [31:0]         data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [31:0]         mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i,
  output logic [LedWidth-1:0] led_o
);

  bus_target_e   instr_tgt_raw, instr_tgt, data_tgt, win_tgt;
  bus_rsp_slot_t slot_q;
  logic [LedWidth-1:0] led_q;
  logic prio_instr;
  logic instr_win, data_win, slot_live;
  logic [31:0] rsp_rdata;

  ibex_bus_decode #(.MemSize(MemSize), .MemStart(MemStart), .LedAddr(LedAddr)) u_dec_instr (
    .addr   (instr_addr_i),
    .target (instr_tgt_raw)
  );

  ibex_bus_decode #(.MemSize(MemSize), .MemStart(MemStart), .LedAddr(LedAddr)) u_dec_data (
    .addr   (data_addr_i),
    .target (data_tgt)
  );

  // The LED register is data-only; fetching from it is a bus error.
  assign instr_tgt = (instr_tgt_raw == TgtLed) ? TgtErr : instr_tgt_raw;

  always_comb begin
    instr_win = 1'b0;
    data_win  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        instr_win = prio_instr;
        data_win  = !prio_instr;
      end else begin
        instr_win = instr_req_i;
        data_win  = data_req_i;
      end
    end
  end

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;
  assign win_tgt     = data_win ? data_tgt : instr_tgt;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (instr_win && instr_tgt == TgtSram) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i;
    end else if (data_win && data_tgt == TgtSram) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_instr <= 1'b1;
      led_q      <= '0;
      slot_q     <= '0;
    end else begin
      if (instr_req_i && data_req_i) begin
        prio_instr <= !instr_win;
      end
      if (data_win && data_we_i && data_tgt == TgtLed && data_be_i[0]) begin
        led_q <= data_wdata_i[LedWidth-1:0];
      end
      slot_q.valid     <= instr_win || data_win;
      slot_q.host      <= data_win ? HostData : HostInstr;
      slot_q.target    <= win_tgt;
      slot_q.we        <= data_win && data_we_i;
      slot_q.led_rdata <= 32'(led_q);
    end
  end

  // Gating with rst_i drops a response whose grant preceded a reset.
  assign slot_live = slot_q.valid && !rst_i;

  always_comb begin
    rsp_rdata = '0;
    if (!slot_q.we) begin
      case (slot_q.target)
        TgtSram: rsp_rdata = mem_rdata_i;
        TgtLed:  rsp_rdata = slot_q.led_rdata;
        default: rsp_rdata = '0;
      endcase
    end
  end

  assign instr_rvalid_o = slot_live && (slot_q.host == HostInstr);
  assign data_rvalid_o  = slot_live && (slot_q.host == HostData);
  assign instr_rdata_o  = instr_rvalid_o ? rsp_rdata : '0;
  assign data_rdata_o   = data_rvalid_o ? rsp_rdata : '0;
  assign instr_err_o    = instr_rvalid_o && (slot_q.target == TgtErr);
  assign data_err_o     = data_rvalid_o && (slot_q.target == TgtErr);
  assign led_o          = led_q;

  always_ff @(posedge clk_i) begin
    if (slot_live && slot_q.target == TgtSram) begin
      assert (mem_rvalid_i)
        else $error("mem_rvalid_i low while an SRAM response is due");
    end
  end

endmodule
